// File: rtl/rle_flash_fetch.sv
// rle_flash_fetch: streams RLE words from QSPI flash (0x6B quad read) into a 2-word FIFO for the decoder.
// Ports: clk/rstn clock and async active-low reset; stream_en fetch enable; start_addr first flash byte address;
//        read_next/stop_data decoder pop and restart; data/data_ready FIFO head and non-empty;
//        spi_cs_n/spi_sck/spi_d_out/spi_d_oe/spi_d_in flash interface.
module rle_flash_fetch #(
  parameter int DUMMY_CYCLES   = 8,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stream_en,
  input  logic [23:0] start_addr,
  input  logic        read_next,
  input  logic        stop_data,
  output logic [15:0] data,
  output logic        data_ready,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic [3:0]  spi_d_out,
  output logic [3:0]  spi_d_oe,
  input  logic [3:0]  spi_d_in
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA} state_t;
  state_t      r_state, w_next;
  logic        r_sck, r_cs_n;
  logic [4:0]  r_bcnt, w_last_cnt;
  logic [31:0] r_shift;
  logic [11:0] r_word;
  logic [15:0] r_f0, r_f1, w_word;
  logic [1:0]  r_occ, w_occ_pop;
  logic [3:0]  r_cs_cnt;
  logic        w_abort, w_pop, w_push, w_start, w_last, w_stall, w_tx;
  assign w_abort    = stop_data | ~stream_en;
  assign w_pop      = read_next & (r_occ != 2'd0) & ~w_abort;
  assign w_occ_pop  = r_occ - {1'b0, w_pop};
  assign w_start    = (r_state == IDLE) & ~w_abort & (r_cs_cnt == 4'(CS_HIGH_CYCLES - 1));
  assign w_last_cnt = (r_state == CMD) ? 5'd7 : (r_state == ADDR) ? 5'd23 :
                      (r_state == DUMMY) ? 5'(DUMMY_CYCLES - 1) : 5'd3;
  assign w_last     = r_bcnt == w_last_cnt;
  // a word may only begin when, after this cycle's pop, the FIFO still has a free slot for it
  assign w_stall    = (r_state == DATA) & ~r_sck & (r_bcnt == 5'd0) & (w_occ_pop == 2'd2);
  assign w_push     = (r_state == DATA) & r_sck & w_last & ~w_abort;
  assign w_word     = {r_word, spi_d_in};
  assign w_tx       = (r_state == CMD) | (r_state == ADDR);
  always_comb begin
    w_next = r_state;
    if (w_abort)
      w_next = IDLE;
    else if (r_state == IDLE)
      w_next = w_start ? CMD : IDLE;
    else if (r_sck & w_last)
      w_next = (r_state == CMD) ? ADDR : (r_state == ADDR) ? DUMMY : DATA;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)
      r_state <= IDLE;
    else
      r_state <= w_next;
  // r_sck high marks the high phase; the edge that ends it samples spi_d_in and advances the bit
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_sck    <= 1'b0;
      r_cs_n   <= 1'b1;
      r_bcnt   <= 5'd0;
      r_shift  <= 32'd0;
      r_word   <= 12'd0;
      r_cs_cnt <= 4'd0;
    end else if (r_state == IDLE || w_abort) begin
      r_sck    <= 1'b0;
      r_bcnt   <= 5'd0;
      r_cs_n   <= ~w_start;
      r_cs_cnt <= (r_state != IDLE) ? 4'd0 :
                  (r_cs_cnt == 4'(CS_HIGH_CYCLES - 1)) ? r_cs_cnt : r_cs_cnt + 4'd1;
      r_shift  <= {8'h6B, start_addr};
    end else if (!w_stall) begin
      r_sck <= ~r_sck;
      if (r_sck) begin
        r_shift <= {r_shift[30:0], 1'b0};
        r_bcnt  <= w_last ? 5'd0 : r_bcnt + 5'd1;
        r_word  <= {r_word[7:0], spi_d_in};
      end
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_occ <= 2'd0;
      r_f0  <= 16'd0;
      r_f1  <= 16'd0;
    end else begin
      r_occ <= w_abort ? 2'd0 : w_occ_pop + {1'b0, w_push};
      if (w_push & (w_occ_pop == 2'd0))
        r_f0 <= w_word;
      else if (w_pop)
        r_f0 <= r_f1;
      if (w_push & (w_occ_pop == 2'd1))
        r_f1 <= w_word;
    end
  assign data       = r_f0;
  assign data_ready = r_occ != 2'd0;
  assign spi_cs_n   = r_cs_n;
  assign spi_sck    = r_sck;
  assign spi_d_out  = {3'b000, r_shift[31] & w_tx};
  assign spi_d_oe   = {3'b000, w_tx};
endmodule
